// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the combinational I-cache, predicts JAL
// statically and queues {pc, instr, pred_taken} entries for decode.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [31:0]              icache_addr,
    input  logic [31:0]              icache_instr,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [31:0]              dec_pc,
    output logic [31:0]              dec_instr,
    output logic                     dec_pred_taken,
    output logic [$clog2(DEPTH):0]   fq_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];
    logic        taken_mem [DEPTH];

    logic        push;
    logic        pop;
    logic        is_jal;
    logic [31:0] pc_next;

    function automatic logic signed [31:0] imm_j(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    assign icache_addr    = pc;
    assign dec_valid      = (count != '0);
    assign fq_count       = count;
    assign dec_pc         = pc_mem[rd_ptr];
    assign dec_instr      = instr_mem[rd_ptr];
    assign dec_pred_taken = taken_mem[rd_ptr];

    // A full queue can still take a fetch when decode drains the head in the same cycle.
    assign pop     = dec_valid && dec_ready;
    assign push    = !redirect_valid && ((count < CNT_W'(DEPTH)) || pop);
    assign is_jal  = (icache_instr[6:0] == 7'b1101111);
    assign pc_next = is_jal ? (pc + $unsigned(imm_j(icache_instr))) : (pc + 32'd4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
                taken_mem[i] <= 1'b0;
            end
        end else if (redirect_valid) begin
            // Redirect squashes everything queued, including a pop decode attempted this cycle.
            pc     <= redirect_pc & 32'hFFFF_FFFC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= pc;
                instr_mem[wr_ptr] <= icache_instr;
                taken_mem[wr_ptr] <= is_jal;
                wr_ptr            <= wr_ptr + PTR_W'(1);
                pc                <= pc_next;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule
